// File: rtl/phys_reg_free_list_if.sv
// Rename/retire handshake bundle for the physical-register free list.
// slave = free list side, master = rename/retire side.
interface phys_reg_free_list_if #(
  parameter int PREG_W = 6
);
  logic              alloc_req_1;
  logic              alloc_req_2;
  logic              alloc_gnt;
  logic [PREG_W-1:0] alloc_preg_1;
  logic [PREG_W-1:0] alloc_preg_2;
  logic              free_flag_1;
  logic [PREG_W-1:0] free_ind_1;
  logic              free_flag_2;
  logic [PREG_W-1:0] free_ind_2;
  logic [PREG_W:0]   free_count;
  logic              empty;
  logic              free_err;

  modport slave (
    input  alloc_req_1, alloc_req_2,
    input  free_flag_1, free_ind_1,
    input  free_flag_2, free_ind_2,
    output alloc_gnt, alloc_preg_1, alloc_preg_2,
    output free_count, empty, free_err
  );

  modport master (
    output alloc_req_1, alloc_req_2,
    output free_flag_1, free_ind_1,
    output free_flag_2, free_ind_2,
    input  alloc_gnt, alloc_preg_1, alloc_preg_2,
    input  free_count, empty, free_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// 2-wide physical-register free pool: circular FIFO of indices
// plus a free bitmap that filters double/duplicate frees.
module phys_reg_free_list #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PREG_W    = 6
) (
  input logic clk,
  input logic rst,
  phys_reg_free_list_if.slave bus
);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   cnt_t;

  localparam cnt_t  RST_CNT  = cnt_t'(NUM_PREGS - NUM_AREGS);
  localparam preg_t RST_TAIL = preg_t'(NUM_AREGS);

  preg_t                fifo [NUM_PREGS];
  preg_t                head;
  preg_t                tail;
  preg_t                head_1;
  preg_t                tail_1;
  preg_t                preg_1;
  preg_t                preg_2;
  cnt_t                 count;
  logic [NUM_PREGS-1:0] bitmap;
  logic                 err;
  logic [1:0]           need;
  logic [1:0]           n_free;
  logic                 gnt;
  logic                 dup;
  logic                 ok_1;
  logic                 ok_2;
  logic                 bad_1;
  logic                 bad_2;

  always_comb begin
    head_1 = head + preg_t'(1);
    tail_1 = tail + preg_t'(1);
    preg_1 = fifo[head];
    preg_2 = bus.alloc_req_1 ? fifo[head_1] : fifo[head];
    need   = {1'b0, bus.alloc_req_1} + {1'b0, bus.alloc_req_2};
    gnt    = (need != 2'd0) && (cnt_t'(need) <= count);
    dup    = bus.free_flag_1 && bus.free_flag_2
          && (bus.free_ind_1 == bus.free_ind_2);
    // p0 backs x0: a free of index 0 is neither legal nor an error
    ok_1   = bus.free_flag_1 && (bus.free_ind_1 != '0)
          && !bitmap[bus.free_ind_1];
    bad_1  = bus.free_flag_1 && (bus.free_ind_1 != '0)
          && bitmap[bus.free_ind_1];
    ok_2   = bus.free_flag_2 && (bus.free_ind_2 != '0)
          && !bitmap[bus.free_ind_2] && !dup;
    bad_2  = bus.free_flag_2 && (bus.free_ind_2 != '0)
          && (bitmap[bus.free_ind_2] || dup);
    n_free = {1'b0, ok_1} + {1'b0, ok_2};
  end

  assign bus.alloc_gnt    = gnt;
  assign bus.alloc_preg_1 = preg_1;
  assign bus.alloc_preg_2 = preg_2;
  assign bus.free_count   = count;
  assign bus.empty        = (count == '0);
  assign bus.free_err     = err;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= RST_TAIL;
      count <= RST_CNT;
      err   <= 1'b0;
      for (int i = 0; i < NUM_PREGS; i++) begin
        fifo[i]   <= preg_t'(i + NUM_AREGS);
        bitmap[i] <= (i >= NUM_AREGS);
      end
    end else begin
      if (gnt) begin
        head <= head + preg_t'(need);
        if (bus.alloc_req_1) bitmap[preg_1] <= 1'b0;
        if (bus.alloc_req_2) bitmap[preg_2] <= 1'b0;
      end
      // granted pregs had bit=1, legal frees had bit=0: never the same bit
      if (ok_1) begin
        fifo[tail]               <= bus.free_ind_1;
        bitmap[bus.free_ind_1]   <= 1'b1;
      end
      if (ok_2) begin
        fifo[ok_1 ? tail_1 : tail] <= bus.free_ind_2;
        bitmap[bus.free_ind_2]     <= 1'b1;
      end
      tail  <= tail + preg_t'(n_free);
      count <= count - (gnt ? cnt_t'(need) : cnt_t'(0))
             + cnt_t'(n_free);
      if (bad_1 || bad_2) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list: drain, refill, wrap,
// illegal frees and mid-run reset.
module tb_phys_reg_free_list;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  phys_reg_free_list_if #(.PREG_W(6)) bus ();

  phys_reg_free_list #(
    .NUM_PREGS(64),
    .NUM_AREGS(32),
    .PREG_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc_req_1 = 1'b0;
    bus.alloc_req_2 = 1'b0;
    bus.free_flag_1 = 1'b0;
    bus.free_ind_1  = '0;
    bus.free_flag_2 = 1'b0;
    bus.free_ind_2  = '0;
  endtask

  task automatic chk_cnt(input string nm, input int exp);
    checks++;
    if (bus.free_count !== 7'(exp)) begin
      errors++;
      $display("FAIL %s: free_count=%0d expected %0d",
               nm, bus.free_count, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_cnt("reset_count", 32);
    checks++;
    if (bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_empty: got %b expected 0", bus.empty);
    end
    checks++;
    if (bus.free_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b expected 0", bus.free_err);
    end
    bus.alloc_req_1 = 1'b1;
    #1;
    checks++;
    if (bus.alloc_preg_1 !== 6'd32) begin
      errors++;
      $display("FAIL reset_preg1: got %0d expected 32", bus.alloc_preg_1);
    end
    checks++;
    if (bus.alloc_preg_2 !== 6'd33) begin
      errors++;
      $display("FAIL reset_preg2: got %0d expected 33", bus.alloc_preg_2);
    end
    bus.alloc_req_1 = 1'b0;
    #1;
  endtask

  task automatic test_drain();
    bus.alloc_req_1 = 1'b1;
    bus.alloc_req_2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (bus.alloc_gnt !== 1'b1 ||
          bus.alloc_preg_1 !== 6'(32 + 2 * i) ||
          bus.alloc_preg_2 !== 6'(33 + 2 * i)) begin
        errors++;
        $display("FAIL drain_%0d: gnt=%b p1=%0d p2=%0d expected 1 %0d %0d",
                 i, bus.alloc_gnt, bus.alloc_preg_1, bus.alloc_preg_2,
                 32 + 2 * i, 33 + 2 * i);
      end
      tick();
    end
    chk_cnt("drain_count", 0);
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got %b expected 1", bus.empty);
    end
    checks++;
    if (bus.alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL drain_deny: gnt=%b expected 0", bus.alloc_gnt);
    end
    tick();
    chk_cnt("deny_count", 0);
    idle();
  endtask

  task automatic test_refill();
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd5;
    bus.free_flag_2 = 1'b1;
    bus.free_ind_2  = 6'd7;
    tick();
    idle();
    bus.alloc_req_1 = 1'b1;
    #1;
    chk_cnt("refill_count", 2);
    checks++;
    if (bus.alloc_preg_1 !== 6'd5 || bus.alloc_preg_2 !== 6'd7) begin
      errors++;
      $display("FAIL refill_pregs: p1=%0d p2=%0d expected 5 7",
               bus.alloc_preg_1, bus.alloc_preg_2);
    end
    bus.alloc_req_1 = 1'b0;
    #1;
  endtask

  task automatic test_single_slot();
    bus.alloc_req_1 = 1'b1;
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_1 !== 6'd5) begin
      errors++;
      $display("FAIL single_s1: gnt=%b p1=%0d expected 1 5",
               bus.alloc_gnt, bus.alloc_preg_1);
    end
    tick();
    bus.alloc_req_1 = 1'b0;
    bus.alloc_req_2 = 1'b1;
    #1;
    chk_cnt("single_count", 1);
    checks++;
    if (bus.alloc_gnt !== 1'b1 || bus.alloc_preg_2 !== 6'd7) begin
      errors++;
      $display("FAIL single_s2: gnt=%b p2=%0d expected 1 7",
               bus.alloc_gnt, bus.alloc_preg_2);
    end
    bus.alloc_req_1 = 1'b1;
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b0) begin
      errors++;
      $display("FAIL single_both_deny: gnt=%b expected 0", bus.alloc_gnt);
    end
    tick();
    chk_cnt("single_deny_count", 1);
    bus.alloc_req_1 = 1'b0;
    tick();
    chk_cnt("single_take_count", 0);
    idle();
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd5;
    bus.free_flag_2 = 1'b1;
    bus.free_ind_2  = 6'd7;
    tick();
    idle();
    chk_cnt("single_refill_count", 2);
  endtask

  task automatic test_alloc_free();
    logic [5:0] a, b, c, d, t0, t1;
    bus.alloc_req_1 = 1'b1;
    bus.alloc_req_2 = 1'b1;
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd9;
    bus.free_flag_2 = 1'b1;
    bus.free_ind_2  = 6'd11;
    #1;
    checks++;
    if (bus.alloc_gnt !== 1'b1 ||
        bus.alloc_preg_1 !== 6'd5 || bus.alloc_preg_2 !== 6'd7) begin
      errors++;
      $display("FAIL af_grant: gnt=%b p1=%0d p2=%0d expected 1 5 7",
               bus.alloc_gnt, bus.alloc_preg_1, bus.alloc_preg_2);
    end
    tick();
    idle();
    #1;
    chk_cnt("af_count", 2);
    checks++;
    if (bus.alloc_preg_1 !== 6'd9) begin
      errors++;
      $display("FAIL af_head: p1=%0d expected 9", bus.alloc_preg_1);
    end
    // pool holds a,b; c,d are in use and returned while a,b are taken
    a = 6'd9; b = 6'd11; c = 6'd5; d = 6'd7;
    for (int r = 0; r < 40; r++) begin
      bus.alloc_req_1 = 1'b1;
      bus.alloc_req_2 = 1'b1;
      bus.free_flag_1 = 1'b1;
      bus.free_ind_1  = c;
      bus.free_flag_2 = 1'b1;
      bus.free_ind_2  = d;
      #1;
      checks++;
      if (bus.alloc_gnt !== 1'b1 ||
          bus.alloc_preg_1 !== a || bus.alloc_preg_2 !== b) begin
        errors++;
        $display("FAIL wrap_%0d: gnt=%b p1=%0d p2=%0d expected 1 %0d %0d",
                 r, bus.alloc_gnt, bus.alloc_preg_1, bus.alloc_preg_2,
                 a, b);
      end
      tick();
      t0 = a; t1 = b;
      a = c; b = d;
      c = t0; d = t1;
    end
    idle();
    #1;
    chk_cnt("wrap_count", 2);
    checks++;
    if (bus.alloc_preg_1 !== 6'd9) begin
      errors++;
      $display("FAIL wrap_head: p1=%0d expected 9", bus.alloc_preg_1);
    end
  endtask

  task automatic test_illegal();
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd0;
    tick();
    idle();
    chk_cnt("zero_count", 2);
    checks++;
    if (bus.free_err !== 1'b0) begin
      errors++;
      $display("FAIL zero_err: got %b expected 0", bus.free_err);
    end
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd40;
    tick();
    chk_cnt("free40_count", 3);
    checks++;
    if (bus.free_err !== 1'b0) begin
      errors++;
      $display("FAIL free40_err: got %b expected 0", bus.free_err);
    end
    tick();
    idle();
    chk_cnt("dbl_count", 3);
    checks++;
    if (bus.free_err !== 1'b1) begin
      errors++;
      $display("FAIL dbl_err: got %b expected 1", bus.free_err);
    end
    bus.free_flag_1 = 1'b1;
    bus.free_ind_1  = 6'd12;
    bus.free_flag_2 = 1'b1;
    bus.free_ind_2  = 6'd12;
    tick();
    idle();
    chk_cnt("dup_count", 4);
    bus.alloc_req_1 = 1'b1;
    bus.alloc_req_2 = 1'b1;
    #1;
    checks++;
    if (bus.alloc_preg_1 !== 6'd9 || bus.alloc_preg_2 !== 6'd11) begin
      errors++;
      $display("FAIL dup_pop1: p1=%0d p2=%0d expected 9 11",
               bus.alloc_preg_1, bus.alloc_preg_2);
    end
    tick();
    checks++;
    if (bus.alloc_preg_1 !== 6'd40 || bus.alloc_preg_2 !== 6'd12) begin
      errors++;
      $display("FAIL dup_pop2: p1=%0d p2=%0d expected 40 12",
               bus.alloc_preg_1, bus.alloc_preg_2);
    end
    tick();
    chk_cnt("dup_drained", 0);
  endtask

  task automatic test_reset_mid();
    bus.alloc_req_1 = 1'b1;
    bus.alloc_req_2 = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk_cnt("rst_mid_count", 32);
    checks++;
    if (bus.free_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_err: got %b expected 0", bus.free_err);
    end
    checks++;
    if (bus.alloc_gnt !== 1'b1 ||
        bus.alloc_preg_1 !== 6'd32 || bus.alloc_preg_2 !== 6'd33) begin
      errors++;
      $display("FAIL rst_mid_pregs: gnt=%b p1=%0d p2=%0d expected 1 32 33",
               bus.alloc_gnt, bus.alloc_preg_1, bus.alloc_preg_2);
    end
    tick();
    idle();
    chk_cnt("rst_mid_alloc", 30);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    test_reset();
    test_drain();
    test_refill();
    test_single_slot();
    test_alloc_free();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
